// File: rtl/iir_out_quant.sv
// Output stage for the IIR section: rounds/saturates sfix36_En27 to sfix18_En14 and buffers in a FIFO.
// Optional macro IIR_OUT_SATCNT_EN enables the saturation counter (sat_count tied to 0 otherwise).
module iir_out_quant #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enb_1_3_0,
    input  logic [35:0] In1,
    input  logic        clear,
    output logic [17:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow,
    output logic        sat_flag,
    output logic [15:0] sat_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [36:0] q_ext;
    logic [23:0] q_shr;
    logic [12:0] unused_round_lsbs;
    logic        q_sat;
    logic [17:0] q_data;

    logic [17:0]   s1_data_q, s1_data_d;
    logic          s1_valid_q, s1_valid_d;
    logic          s1_sat_q, s1_sat_d;

    logic [17:0]   mem_q [DEPTH];
    logic [17:0]   mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [17:0]   out_data_q, out_data_d;
    logic          overflow_q, overflow_d;
    logic          sat_flag_q, sat_flag_d;

    logic          full;
    logic          pop;
    logic          push_en;

    // Taking bits [36:13] of the rounded sum is the arithmetic shift by 13.
    always_comb begin
        q_ext             = {In1[35], In1} + 37'd4096;
        q_shr             = q_ext[36:13];
        unused_round_lsbs = q_ext[12:0];
        q_sat             = !((&q_shr[23:17]) || (~|q_shr[23:17]));
        if (q_sat) begin
            q_data = q_shr[23] ? 18'h20000 : 18'h1FFFF;
        end else begin
            q_data = q_shr[17:0];
        end
    end

    always_comb begin
        s1_data_d  = q_data;
        s1_valid_d = enb_1_3_0;
        s1_sat_d   = q_sat && enb_1_3_0;
    end

    always_comb begin
        full    = (count_q == CW'(DEPTH));
        pop     = out_valid && out_ready;
        push_en = s1_valid_q && (!full || pop);

        mem_d = mem_q;
        if (push_en) begin
            mem_d[wr_ptr_q] = s1_data_q;
        end

        wr_ptr_d = push_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

        unique case ({push_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Head register: bypass the incoming sample when it lands at the new read pointer.
        out_data_d = out_data_q;
        if (pop || (push_en && count_q == '0)) begin
            if (push_en && wr_ptr_q == rd_ptr_d) begin
                out_data_d = s1_data_q;
            end else begin
                out_data_d = mem_q[rd_ptr_d];
            end
        end

        overflow_d = overflow_q || (s1_valid_q && !push_en);
        sat_flag_d = sat_flag_q || s1_sat_q;
        if (clear) begin
            overflow_d = 1'b0;
            sat_flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_sat_q   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            out_data_q <= '0;
            overflow_q <= 1'b0;
            sat_flag_q <= 1'b0;
        end else begin
            s1_data_q  <= s1_data_d;
            s1_valid_q <= s1_valid_d;
            s1_sat_q   <= s1_sat_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            out_data_q <= out_data_d;
            overflow_q <= overflow_d;
            sat_flag_q <= sat_flag_d;
        end
    end

`ifdef IIR_OUT_SATCNT_EN
    logic [15:0] sat_count_q, sat_count_d;

    always_comb begin
        sat_count_d = sat_count_q;
        if (s1_sat_q && sat_count_q != 16'hFFFF) begin
            sat_count_d = sat_count_q + 16'd1;
        end
        if (clear) begin
            sat_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sat_count_q <= '0;
        end else begin
            sat_count_q <= sat_count_d;
        end
    end

    assign sat_count = sat_count_q;
`else
    assign sat_count = '0;
`endif

    assign out_data  = out_data_q;
    assign out_valid = (count_q != '0);
    assign overflow  = overflow_q;
    assign sat_flag  = sat_flag_q;

endmodule

// File: tb/tb_iir_out_quant.sv
// Directed bench for iir_out_quant: expected samples are queued at drive time and checked on each handshake.
module tb_iir_out_quant;

    logic        clk = 1'b0;
    logic        reset;
    logic        enb_1_3_0;
    logic [35:0] In1;
    logic        clear;
    logic [17:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;
    logic        sat_flag;
    logic [15:0] sat_count;

    int checks = 0;
    int errors = 0;
    logic signed [31:0] sb [$];

    iir_out_quant #(.DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .enb_1_3_0 (enb_1_3_0),
        .In1       (In1),
        .clear     (clear),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .sat_flag  (sat_flag),
        .sat_count (sat_count)
    );

    always #5 clk = ~clk;

    function automatic logic signed [31:0] quant(input longint x);
        longint r;
        r = (x + 64'sd4096) >>> 13;
        if (r > 64'sd131071) r = 64'sd131071;
        if (r < -64'sd131072) r = -64'sd131072;
        return 32'(r);
    endfunction

    function automatic int exp_cnt(input int n);
`ifdef IIR_OUT_SATCNT_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Evaluate the handshake in the current cycle, then advance to just after the next edge.
    task automatic tick();
        logic signed [31:0] e;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("pop_without_expected", 32'(out_valid), 0);
            end else begin
                e = sb.pop_front();
                chk("out_data", 32'($signed(out_data)), e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic enable_cycle(input longint x, input bit accept);
        In1 = 36'(x);
        enb_1_3_0 = 1'b1;
        if (accept) sb.push_back(quant(x));
        tick();
        enb_1_3_0 = 1'b0;
    endtask

    task automatic sample(input longint x, input bit accept);
        enable_cycle(x, accept);
        tick();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        enb_1_3_0 = 1'b0;
        In1 = '0;
        clear = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        tick();
        reset = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_sat_flag", 32'(sat_flag), 0);
        chk("rst_sat_count", 32'(sat_count), 0);

        // Unity gain and latency
        out_ready = 1'b1;
        enable_cycle(64'sd134217728, 1'b1);
        chk("unity_valid_t1", 32'(out_valid), 0);
        tick();
        chk("unity_valid_t2", 32'(out_valid), 1);
        chk("unity_data_t2", 32'($signed(out_data)), 16384);
        tick();
        chk("unity_valid_t3", 32'(out_valid), 0);
        chk("unity_sat_flag", 32'(sat_flag), 0);

        // Rounding boundaries
        sample(64'sd4096, 1'b1);
        sample(64'sd4095, 1'b1);
        sample(-64'sd4096, 1'b1);
        sample(-64'sd4097, 1'b1);
        chk("round_sat_flag", 32'(sat_flag), 0);

        // Saturation and clear
        sample(64'sd17179869184, 1'b1);
        chk("sat_hi_count", 32'(sat_count), exp_cnt(1));
        chk("sat_hi_flag", 32'(sat_flag), 1);
        sample(-64'sd34359738368, 1'b1);
        chk("sat_lo_count", 32'(sat_count), exp_cnt(2));
        chk("sat_lo_flag", 32'(sat_flag), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_sat_flag", 32'(sat_flag), 0);
        chk("clear_sat_count", 32'(sat_count), 0);

        // Backpressure: fifth sample dropped
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            sample(longint'(k) * 64'sd8192, k <= 4);
        end
        chk("bp_overflow", 32'(overflow), 1);
        chk("bp_hold_valid", 32'(out_valid), 1);
        chk("bp_hold_data", 32'($signed(out_data)), 1);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("bp_drain_valid", 32'(out_valid), 1);
            tick();
        end
        chk("bp_empty", 32'(out_valid), 0);

        // Full plus simultaneous pop
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_overflow", 32'(overflow), 0);
        out_ready = 1'b0;
        for (int k = 10; k <= 13; k++) begin
            sample(longint'(k) * 64'sd8192, 1'b1);
        end
        enable_cycle(64'sd14 * 64'sd8192, 1'b1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        tick();
        chk("fullpop_overflow", 32'(overflow), 0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("fullpop_drain_valid", 32'(out_valid), 1);
            tick();
        end
        chk("fullpop_empty", 32'(out_valid), 0);

        // Reset mid-stream
        out_ready = 1'b0;
        sample(64'sd17179869184, 1'b1);
        sample(64'sd3 * 64'sd8192, 1'b1);
        chk("pre_rst_sat_flag", 32'(sat_flag), 1);
        chk("pre_rst_valid", 32'(out_valid), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_overflow", 32'(overflow), 0);
        chk("midrst_sat_flag", 32'(sat_flag), 0);
        chk("midrst_sat_count", 32'(sat_count), 0);
        out_ready = 1'b1;
        enable_cycle(64'sd5 * 64'sd8192, 1'b1);
        chk("post_rst_valid_t1", 32'(out_valid), 0);
        tick();
        chk("post_rst_valid_t2", 32'(out_valid), 1);
        tick();
        chk("post_rst_valid_t3", 32'(out_valid), 0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
